pixel_gen_scaled: RTL and testbench
===================================

# pixel_gen_scaled

Parametrised successor to the fixed 2x framebuffer pixel generator. It sits between the VGA timing generator and the DAC outputs. It generates framebuffer ROM addresses for an integer-power-of-two upscaled image without a multiplier, and aligns timing and control signals to the ROM read latency. It also provides selectable test-pattern modes that switch only at frame boundaries.

## Interface
Parameters:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 800: active lines per frame.
- IMG_W, 640: image width in source pixels.
- IMG_H, 400: image height in source pixels.
- SCALE_LOG2, 1: upscale factor is 2^SCALE_LOG2 (legal values 0..3).
- CB, 4: colour bits per channel in ROM words.
- ADDR_W, 18: ROM address width.
- ROM_LAT, 1: ROM read latency in cycles (legal values 1..2).
- SYNC_IDLE, 1'b1: reset and inactive level of the delayed syncs.

Ports:
- VGA_CLK, in, 1: pixel clock.
- reset, in, 1: asynchronous, active-high.
- line_value, in, 16: current line from the timing generator.
- pixel_location, in, 16: current pixel from the timing generator.
- visible_region, in, 1: active video.
- hsync_in, in, 1: raw sync from the timing generator.
- vsync_in, in, 1: raw sync from the timing generator.
- mode, in, 2: 0 = image, 1 = colour bars, 2 = solid bg_color, 3 = grid.
- bg_color, in, 3*CB: {R,G,B} used outside the image and in mode 2.
- rom_address, out, ADDR_W: registered address to the external ROM.
- rom_q, in, 3*CB: {R,G,B} data, valid ROM_LAT cycles after rom_address.
- VGA_R, out, 8: red channel.
- VGA_G, out, 8: green channel.
- VGA_B, out, 8: blue channel.
- VGA_HS, out, 1: delayed hsync.
- VGA_VS, out, 1: delayed vsync.
- VGA_BLANK_N, out, 1: delayed visible_region.

## Operation
- **Frame start.** The frame-start cycle is the cycle where line_value==0 and pixel_location==0. mode_q latches mode only on this cycle, so a mode change mid-frame takes effect on the next frame.
- **Row tracking.** No multiplier is used.
  - line_q registers line_value. A new line is detected when line_value != line_q.
  - On a new line with line_value==0: row_base=0 and sub=0.
  - On any other new line: if sub==2^SCALE_LOG2-1, then sub=0 and row_base+=IMG_W; otherwise sub increments.
  - row_base is ADDR_W wide.
- **Column and in-image flag.**
  - col = pixel_location>>SCALE_LOG2.
  - in_img = (col<IMG_W) && ((line_value>>SCALE_LOG2)<IMG_H).
- **Address register.**
  - rom_address <= row_base+col when in_img; otherwise it holds its last value.
  - Truncation to ADDR_W is permitted. The parameters must satisfy IMG_W*IMG_H <= 2^ADDR_W.
- **Colour bars (mode 1).**
  - A bar counter (0..7) and an intra-bar pixel counter both clear at pixel_location==0.
  - The bar counter advances every H_ACTIVE/8 pixels (integer division) and saturates at 7.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
- **Grid (mode 3).** White when pixel_location[5:0]==0 or line_value[5:0]==0; bg_color otherwise.
- **Colour expansion.** Each CB-bit channel is expanded to 8 bits by bit replication, e.g. 4'hA -> 8'hAA.
- **Output select.**
  - visible low: all colour outputs are 0.
  - Mode 0: rom_q if in_img was true for that pixel, else bg_color.
  - Mode 2: bg_color everywhere.

## Timing
- Pipeline latency from inputs to VGA outputs is L = 2+ROM_LAT cycles (3 by default):
  - stage A: address and control registers;
  - ROM_LAT cycles of ROM read;
  - output register.
- visible_region, hsync_in, vsync_in, in_img, mode_q and the pattern colour travel through a matching L-1 stage shift register. Colour and sync always leave in the same cycle.
- Reset values:
  - rom_address, row_base, sub, counters and VGA_R/G/B: 0.
  - VGA_BLANK_N: 0.
  - VGA_HS and VGA_VS: SYNC_IDLE.
  - mode_q: 0.
  - All pipeline stages are cleared.
- Reset asserted mid-line: outputs reach their reset values immediately. After release, correct output resumes at the next frame start plus L. Any partial frame before that is don't-care except that blanking must be correct.
- Simultaneous new-line and frame-start events: the frame-start rule wins, setting row_base=0 and sub=0.

## Structure
- Package pixel_gen_pkg holds:
  - mode_e enum (MODE_IMAGE, MODE_BARS, MODE_SOLID, MODE_GRID);
  - the bar colour constant array;
  - the expand_chan function for bit replication.
- Sub-module pixel_addr_gen contains the row/sub/column tracking and the registered rom_address plus the in_img flag. The top level contains the pattern logic, the delay line and the output mux.

## Test plan
- **Reset:** assert reset mid-line -> VGA_R/G/B=0, VGA_BLANK_N=0, VGA_HS=VGA_VS=1, rom_address=0 in the same cycle.
- **Image mode, SCALE_LOG2=1:** drive line 3, pixel 5 -> rom_address=642 one cycle later. Return rom_q=12'hABC -> VGA_R=8'hAA, VGA_G=8'hBB, VGA_B=8'hCC exactly 3 cycles after the input.
- **Outside image, SCALE_LOG2=0, bg_color=12'h123:** pixel 700 -> outputs 8'h11, 8'h22, 8'h33. rom_address is unchanged.
- **Colour bars:** pixel 0 -> FF,FF,FF; pixel 160 -> FF,FF,00; pixel 1279 -> 00,00,00.
- **Mode change:** set mode=1 at line 200 -> image output persists until the next frame start, then bars appear with latency 3.
- **Blanking:** visible_region=0 with rom_q=12'hFFF -> colour outputs 0. Syncs toggled on input reappear unchanged 3 cycles later.

Source files
------------

// File: rtl/pixel_gen_pkg.sv
// Shared types, constants and helpers for the scaled framebuffer pixel generator.
package pixel_gen_pkg;

    typedef enum logic [1:0] {
        MODE_IMAGE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_GRID  = 2'd3
    } mode_e;

    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    typedef struct packed {
        logic        vis;
        logic        hs;
        logic        vs;
        logic        in_img;
        mode_e       mode;
        logic [23:0] pat;
    } ctl_t;

    // Replicate the low cb bits of c, MSB first, to fill 8 bits.
    function automatic logic [7:0] expand_chan(input logic [7:0] c, input int unsigned cb);
        logic [7:0] r;
        logic [2:0] idx;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = 3'(cb - 1 - (i % cb));
            r[3'(7 - i)] = c[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Multiplier-free framebuffer address generation for a power-of-two upscaled image.
module pixel_addr_gen
    import pixel_gen_pkg::*;
#(
    parameter int V_ACTIVE   = 800,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 400,
    parameter int SCALE_LOG2 = 1,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       line_value,
    input  logic [15:0]       pixel_location,
    output logic [ADDR_W-1:0] rom_address,
    output logic              in_img
);

    localparam logic [15:0]       IMG_W16  = 16'(IMG_W);
    localparam logic [15:0]       IMG_H16  = 16'(IMG_H);
    localparam logic [15:0]       V_ACT16  = 16'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [2:0]        SUB_MAX  = 3'((1 << SCALE_LOG2) - 1);

    logic [15:0]       line_q;
    logic [ADDR_W-1:0] row_base, row_nxt;
    logic [2:0]        sub, sub_nxt;
    logic [15:0]       col;
    logic              new_line, frame_start, img_hit;

    always_comb begin
        new_line    = (line_value != line_q);
        frame_start = (line_value == 16'd0) && (pixel_location == 16'd0);
        row_nxt     = row_base;
        sub_nxt     = sub;
        if (frame_start || (new_line && line_value == 16'd0)) begin
            row_nxt = '0;
            sub_nxt = '0;
        end else if (new_line) begin
            if (sub == SUB_MAX) begin
                sub_nxt = '0;
                row_nxt = row_base + ROW_STEP;
            end else begin
                sub_nxt = sub + 3'd1;
            end
        end
        col     = pixel_location >> SCALE_LOG2;
        img_hit = (col < IMG_W16) && ((line_value >> SCALE_LOG2) < IMG_H16)
                  && (line_value < V_ACT16);
    end

    // Address uses the updated row so the first pixel of a new line already lands on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q      <= '0;
            row_base    <= '0;
            sub         <= '0;
            in_img      <= 1'b0;
            rom_address <= '0;
        end else begin
            line_q   <= line_value;
            row_base <= row_nxt;
            sub      <= sub_nxt;
            in_img   <= img_hit;
            if (img_hit)
                rom_address <= row_nxt + ADDR_W'(col);
        end
    end

endmodule

// File: rtl/pixel_gen_scaled.sv
// Upscaled framebuffer pixel generator with test patterns and ROM-latency-matched timing.
module pixel_gen_scaled
    import pixel_gen_pkg::*;
#(
    parameter int   H_ACTIVE   = 1280,
    parameter int   V_ACTIVE   = 800,
    parameter int   IMG_W      = 640,
    parameter int   IMG_H      = 400,
    parameter int   SCALE_LOG2 = 1,
    parameter int   CB         = 4,
    parameter int   ADDR_W     = 18,
    parameter int   ROM_LAT    = 1,
    parameter logic SYNC_IDLE  = 1'b1
) (
    input  logic              VGA_CLK,
    input  logic              reset,
    input  logic [15:0]       line_value,
    input  logic [15:0]       pixel_location,
    input  logic              visible_region,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [1:0]        mode,
    input  logic [3*CB-1:0]   bg_color,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [3*CB-1:0]   rom_q,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N
);

    localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);
    localparam ctl_t CTL_RST = '{vis: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE, in_img: 1'b0,
                                 mode: MODE_IMAGE, pat: 24'd0};

    logic        in_img_a;
    logic [2:0]  bar_q, bar_cur;
    logic [15:0] cnt_q, cnt_cur;
    logic [2:0]  bar_rgb;
    logic [23:0] bg24, bar24, pat;
    mode_e       mode_q, mode_eff;
    logic        frame_start;
    logic        vis_a, hs_a, vs_a;
    mode_e       mode_a;
    logic [23:0] pat_a;
    ctl_t        stage_a;
    ctl_t        pipe [ROM_LAT];

    pixel_addr_gen #(
        .V_ACTIVE   (V_ACTIVE),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .SCALE_LOG2 (SCALE_LOG2),
        .ADDR_W     (ADDR_W)
    ) u_addr (
        .clk            (VGA_CLK),
        .rst            (reset),
        .line_value     (line_value),
        .pixel_location (pixel_location),
        .rom_address    (rom_address),
        .in_img         (in_img_a)
    );

    always_comb begin
        frame_start = (line_value == 16'd0) && (pixel_location == 16'd0);
        mode_eff    = frame_start ? mode_e'(mode) : mode_q;
        bar_cur     = (pixel_location == 16'd0) ? 3'd0 : bar_q;
        cnt_cur     = (pixel_location == 16'd0) ? 16'd0 : cnt_q;
        bar_rgb     = BAR_RGB[bar_cur];
        bar24       = {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}};
        bg24        = {expand_chan(8'(bg_color[3*CB-1 -: CB]), CB),
                       expand_chan(8'(bg_color[2*CB-1 -: CB]), CB),
                       expand_chan(8'(bg_color[CB-1   -: CB]), CB)};
        unique case (mode_eff)
            MODE_BARS: pat = bar24;
            MODE_GRID: pat = (pixel_location[5:0] == 6'd0 || line_value[5:0] == 6'd0)
                             ? 24'hFFFFFF : bg24;
            default:   pat = bg24;
        endcase
        stage_a = '{vis: vis_a, hs: hs_a, vs: vs_a, in_img: in_img_a, mode: mode_a, pat: pat_a};
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_IMAGE;
            bar_q  <= '0;
            cnt_q  <= '0;
            vis_a  <= 1'b0;
            hs_a   <= SYNC_IDLE;
            vs_a   <= SYNC_IDLE;
            mode_a <= MODE_IMAGE;
            pat_a  <= '0;
        end else begin
            mode_q <= mode_eff;
            if (cnt_cur == BAR_LAST) begin
                cnt_q <= '0;
                bar_q <= (bar_cur == 3'd7) ? 3'd7 : bar_cur + 3'd1;
            end else begin
                cnt_q <= cnt_cur + 16'd1;
                bar_q <= bar_cur;
            end
            vis_a  <= visible_region;
            hs_a   <= hsync_in;
            vs_a   <= vsync_in;
            mode_a <= mode_eff;
            pat_a  <= pat;
        end
    end

    // Stage A plus ROM_LAT delay stages keep control aligned with rom_q.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROM_LAT; i++)
                pipe[i] <= CTL_RST;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= SYNC_IDLE;
            VGA_VS      <= SYNC_IDLE;
            VGA_BLANK_N <= 1'b0;
        end else begin
            pipe[0] <= stage_a;
            for (int unsigned i = 1; i < ROM_LAT; i++)
                pipe[i] <= pipe[i-1];
            VGA_HS      <= pipe[ROM_LAT-1].hs;
            VGA_VS      <= pipe[ROM_LAT-1].vs;
            VGA_BLANK_N <= pipe[ROM_LAT-1].vis;
            if (!pipe[ROM_LAT-1].vis) begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end else if (pipe[ROM_LAT-1].mode == MODE_IMAGE && pipe[ROM_LAT-1].in_img) begin
                VGA_R <= expand_chan(8'(rom_q[3*CB-1 -: CB]), CB);
                VGA_G <= expand_chan(8'(rom_q[2*CB-1 -: CB]), CB);
                VGA_B <= expand_chan(8'(rom_q[CB-1   -: CB]), CB);
            end else begin
                VGA_R <= pipe[ROM_LAT-1].pat[23:16];
                VGA_G <= pipe[ROM_LAT-1].pat[15:8];
                VGA_B <= pipe[ROM_LAT-1].pat[7:0];
            end
        end
    end

endmodule

// File: tb/tb_pixel_gen_scaled.sv
// Directed bench for pixel_gen_scaled: 2x-scaled and unscaled instances share stimulus.
module tb_pixel_gen_scaled;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] line_value, pixel_location;
    logic        visible_region, hsync_in, vsync_in;
    logic [1:0]  mode;
    logic [11:0] bg_color, rom_q;

    logic [17:0] addr1, addr0;
    logic [7:0]  r1, g1, b1, r0, g0, b0;
    logic        hs1, vs1, bl1, hs0, vs0, bl0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pixel_gen_scaled #(.SCALE_LOG2(1)) dut (
        .VGA_CLK(clk), .reset(rst), .line_value(line_value), .pixel_location(pixel_location),
        .visible_region(visible_region), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mode(mode), .bg_color(bg_color), .rom_address(addr1), .rom_q(rom_q),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1)
    );

    pixel_gen_scaled #(.SCALE_LOG2(0)) dut0 (
        .VGA_CLK(clk), .reset(rst), .line_value(line_value), .pixel_location(pixel_location),
        .visible_region(visible_region), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .mode(mode), .bg_color(bg_color), .rom_address(addr0), .rom_q(rom_q),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bl0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ln, input int px);
        line_value     = 16'(ln);
        pixel_location = 16'(px);
    endtask

    logic [1:0] sync_pat [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b11};

    initial begin
        rst = 1'b1;
        drive(0, 0);
        visible_region = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        mode = 2'd0;
        bg_color = 12'h000;
        rom_q = 12'h000;
        tick();
        tick();
        check("rst_rgb",   {r1, g1, b1}, 24'h0);
        check("rst_blank", bl1, 1'b0);
        check("rst_sync",  {hs1, vs1}, 2'b11);
        check("rst_addr",  addr1, 18'd0);

        // Image mode: walk lines 0..3 blanked, then one visible pixel at line 3, pixel 5
        rst = 1'b0;
        tick();
        drive(0, 0); tick();
        drive(1, 0); tick();
        drive(2, 0); tick();
        drive(3, 5); visible_region = 1'b1; tick();
        check("img_addr_s1", addr1, 18'd642);
        check("img_addr_s0", addr0, 18'd1925);
        rom_q = 12'hABC;
        visible_region = 1'b0;
        tick();
        check("img_early_blank", bl1, 1'b0);
        check("img_early_r", r1, 8'h00);
        tick();
        check("img_blank", bl1, 1'b1);
        check("img_rgb", {r1, g1, b1}, 24'hAABBCC);
        tick();
        check("img_late_blank", bl1, 1'b0);

        // Outside image on the unscaled instance: background, address held
        bg_color = 12'h123;
        drive(3, 700); visible_region = 1'b1; tick();
        check("out_addr_hold", addr0, 18'd1925);
        tick();
        tick();
        check("out_rgb", {r0, g0, b0}, 24'h112233);

        // Colour bars across a whole line; output lags input by two ticks here
        mode = 2'd1;
        for (int p = 0; p < 1280; p++) begin
            drive(0, p);
            tick();
            case (p - 2)
                0:    check("bar_p0",    {r1, g1, b1}, 24'hFFFFFF);
                159:  check("bar_p159",  {r1, g1, b1}, 24'hFFFFFF);
                160:  check("bar_p160",  {r1, g1, b1}, 24'hFFFF00);
                1119: check("bar_p1119", {r1, g1, b1}, 24'h0000FF);
                default: ;
            endcase
        end
        tick();
        tick();
        check("bar_p1279", {r1, g1, b1}, 24'h000000);

        // Mode change mid-frame waits for the next frame start
        mode = 2'd0;
        rom_q = 12'hABC;
        drive(0, 0); tick();
        mode = 2'd1;
        drive(200, 10); tick();
        tick();
        tick();
        check("mode_hold_img", {r1, g1, b1}, 24'hAABBCC);
        drive(0, 0); tick();
        tick();
        check("mode_pre_switch", {r1, g1, b1}, 24'hAABBCC);
        tick();
        check("mode_bars_on", {r1, g1, b1}, 24'hFFFFFF);

        // Blanking with a full-scale ROM word, syncs pass through with latency 3
        mode = 2'd0;
        rom_q = 12'hFFF;
        visible_region = 1'b0;
        drive(5, 3);
        for (int k = 0; k < 6; k++) begin
            {hsync_in, vsync_in} = sync_pat[k];
            tick();
            if (k >= 2) begin
                check("blank_sync", {hs1, vs1}, sync_pat[k-2]);
                check("blank_rgb", {r1, g1, b1}, 24'h0);
            end
        end

        // Reset asserted mid-line takes effect without a clock edge
        rom_q = 12'hABC;
        visible_region = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        drive(0, 0); tick();
        drive(0, 5); tick();
        tick();
        tick();
        check("pre_rst_rgb", {r1, g1, b1}, 24'hAABBCC);
        check("pre_rst_addr", addr1, 18'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rgb",   {r1, g1, b1}, 24'h0);
        check("mid_rst_blank", bl1, 1'b0);
        check("mid_rst_sync",  {hs1, vs1}, 2'b11);
        check("mid_rst_addr",  addr1, 18'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
